// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // RV32I funct3 width/sign codes; store and load byte/half codes share values.
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Any funct3 that is not a recognised byte/half code behaves as a word.
    function automatic size_e access_size(input logic store, input logic [2:0] f3);
        if (store) begin
            if (f3 == FUNCT3_SB) return SZ_BYTE;
            if (f3 == FUNCT3_SH) return SZ_HALF;
            return SZ_WORD;
        end
        if (f3 == FUNCT3_LB || f3 == FUNCT3_LBU) return SZ_BYTE;
        if (f3 == FUNCT3_LH || f3 == FUNCT3_LHU) return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half/word of a read word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (load code), addr_lo (byte offset), rdata (memory word) -> data (extended result).
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    size_e       sz;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    always_comb begin
        sz       = access_size(1'b0, funct3);
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        // funct3[2] marks the unsigned variants (LBU/LHU).
        sign_en  = ~funct3[2];
        case (sz)
            SZ_BYTE: data = {{24{sign_en & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_en & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store per handshake to a variable-latency single-port data memory.
// Latency: accept at N, dmem_req from N+1, resp_valid one cycle after dmem_ack (earliest N+2).
// Backpressure: req_ready only in IDLE; one request in flight; dmem_req held until ack or timeout.
// Ports: req_* / is_load / is_store / funct3 / addr / w_data in; dmem_* bus; resp_valid, mem_r_data,
//        bus_err, misaligned out. Optional MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    output logic [31:0] mem_r_data,
    output logic        bus_err,
    output logic        misaligned
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_q, resp_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;

    logic        new_store;
    logic        trap_mis;
    logic        busy;
    logic        timeout_hit;
    logic [31:0] ext_data;
    logic [3:0]  strb;
    logic [31:0] wrep;

    // Both op bits set resolves to a load.
    assign new_store = (is_store == ENABLE) && (is_load == DISABLE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap_mis = is_misaligned(access_size(new_store, funct3), addr[1:0]);
`else
    assign trap_mis = 1'b0;
`endif

    assign busy        = (state_q == ST_BUSY);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    load_extend u_load_extend (
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (dmem_rdata),
        .data    (ext_data)
    );

    always_comb begin
        case (access_size(store_q, funct3_q))
            SZ_BYTE: begin
                strb = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                strb = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wrep = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = 1'b0;
        err_d    = 1'b0;
        mis_d    = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_load || is_store) begin
                        store_d  = new_store;
                        funct3_d = funct3;
                        addr_d   = addr;
                        wdata_d  = w_data;
                        if (trap_mis) begin
                            resp_d  = 1'b1;
                            mis_d   = 1'b1;
                            rdata_d = '0;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = '0;
                        end
                    end else begin
                        // No operation: answer immediately without touching memory.
                        resp_d  = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (dmem_ack) begin
                    resp_d  = 1'b1;
                    rdata_d = store_q ? '0 : ext_data;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            resp_q   <= 1'b0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus outputs are forced to zero outside BUSY so idle state is quiet.
    assign req_ready  = (state_q == ST_IDLE);
    assign dmem_req   = busy;
    assign dmem_we    = busy & store_q;
    assign dmem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
    assign dmem_wstrb = (busy & store_q) ? strb : 4'b0000;
    assign dmem_wdata = (busy & store_q) ? wrep : '0;
    assign resp_valid = resp_q;
    assign mem_r_data = rdata_q;
    assign bus_err    = err_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized loads/stores against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        resp_valid;
    logic [31:0] mem_r_data;
    logic        bus_err;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .w_data     (w_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .resp_valid (resp_valid),
        .mem_r_data (mem_r_data),
        .bus_err    (bus_err),
        .misaligned (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes from the instruction's encoding.
    function automatic int nbytes(input bit store, input logic [2:0] f3);
        if (store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input int n, input logic [31:0] a);
        return (a % n) != 0;
    endfunction

    function automatic int lane_off(input int n, input logic [31:0] a);
        return (n == 1) ? int'(a % 4) : (n == 2) ? int'(((a % 4) / 2) * 2) : 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int     n;
        longint v;
        longint span;
        n    = nbytes(1'b0, f3);
        span = longint'(1) << (8 * n);
        v    = (longint'(rd) >> (8 * lane_off(n, a))) % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input int n, input logic [31:0] a);
        int s;
        s = ((1 << n) - 1) << lane_off(n, a);
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // Runs one request from an IDLE cycle to its response cycle; ack after 'delay' unacked BUSY cycles.
    task automatic access(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd,
                          input string tag);
        bit store;
        bit none;
        bit mis;
        int n;
        store = st && !ld;
        none  = !ld && !st;
        n     = nbytes(store, f3);
        mis   = TRAP_EN && !none && model_mis(n, a);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; w_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        if (none || mis) begin
            check({tag, ".byp_resp_req"}, {30'd0, resp_valid, dmem_req}, 32'b10);
            check({tag, ".byp_data"}, mem_r_data, 32'd0);
            check({tag, ".byp_mis"}, 32'(misaligned), 32'(mis));
        end else begin
            check({tag, ".req"}, 32'(dmem_req), 32'd1);
            check({tag, ".daddr"}, dmem_addr, {a[31:2], 2'b00});
            check({tag, ".we"}, 32'(dmem_we), 32'(store));
            if (store) begin
                check({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(model_strb(n, a)));
                check({tag, ".wdata"}, dmem_wdata, model_wdata(n, wd));
            end
            for (int k = 0; k < delay; k++) begin
                @(posedge clk); #1;
                check({tag, ".wait"}, {30'd0, dmem_req, resp_valid}, 32'b10);
            end
            dmem_ack = 1'b1; dmem_rdata = rd;
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            check({tag, ".resp"}, {28'd0, resp_valid, bus_err, misaligned, dmem_req}, 32'b1000);
            check({tag, ".rdata"}, mem_r_data, store ? 32'd0 : model_load(f3, a, rd));
        end
    endtask

    initial begin
        int idx;
        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; addr = '0; w_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.ready", 32'(req_ready), 32'd1);
        check("reset.outs", {26'd0, resp_valid, bus_err, misaligned, dmem_req, dmem_we, 1'b0}, 32'd0);
        check("reset.bus", dmem_addr | dmem_wdata | 32'(dmem_wstrb) | mem_r_data, 32'd0);

        // Directed cases.
        access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h8000_0000, "lb_sext");
        check("lb_sext.value", mem_r_data, 32'hFFFF_FF80);
        @(posedge clk); #1;
        check("hold.data", mem_r_data, 32'hFFFF_FF80);
        check("hold.resp", 32'(resp_valid), 32'd0);
        access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 3, 32'hBEEF_1234, "lhu");
        check("lhu.value", mem_r_data, 32'h0000_BEEF);
        access(1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00A5, 1, 32'h1234_5678, "sb");
        access(1'b0, 1'b1, 3'd1, 32'h202, 32'hCAFE_1234, 0, 32'h0, "sh_hi");
        access(1'b1, 1'b1, 3'd2, 32'h300, 32'h0, 0, 32'h1357_9BDF, "both_is_load");
        check("both_is_load.value", mem_r_data, 32'h1357_9BDF);
        access(1'b0, 1'b0, 3'd2, 32'h400, 32'hFFFF_FFFF, 0, 32'h0, "noop");
        access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 0, 32'hDEAD_BEEF, "lw_mis");
        access(1'b1, 1'b0, 3'd7, 32'h500, 32'h0, 2, 32'h8765_4321, "lw_undef_f3");

        // Timeout: no ack ever; response expected after 16 BUSY cycles.
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h600;
        @(posedge clk); #1;
        req_valid = 1'b0; is_load = 1'b0;
        idx = 1;
        while (!resp_valid && idx < 40) begin
            @(posedge clk); #1;
            idx++;
        end
        check("timeout.cycle", 32'(idx), 32'd17);
        check("timeout.flags", {29'd0, bus_err, misaligned, dmem_req}, 32'b100);
        check("timeout.data", mem_r_data, 32'd0);

        // Reset in BUSY followed by a late ack: nothing must come back.
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h700;
        @(posedge clk); #1;
        req_valid = 1'b0; is_load = 1'b0;
        check("rstbusy.req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstbusy.idle", {30'd0, req_ready, dmem_req}, 32'b10);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("rstbusy.noresp", {30'd0, resp_valid, dmem_req}, 32'b00);
        check("rstbusy.data", mem_r_data, 32'd0);

        // Randomized traffic, issued back to back from response cycles.
        for (int t = 0; t < 60; t++) begin
            int          sel;
            logic        ld;
            logic        st;
            sel = $urandom_range(0, 9);
            ld  = (sel == 1) || (sel >= 2 && sel <= 5);
            st  = (sel == 1) || (sel >= 6);
            access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 4), $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
